// File: rtl/skewed_desync_u.sv
// ---------------------------------------------------------------------------
// skewed_desync_u
//
// Purpose:
//   Decorrelates a pair of unipolar stochastic bitstreams. This block is the
//   counterpart of the skewed synchronizer: it keeps 1s from the two streams
//   from landing in the same cycle.
//   - When both inputs are 1, one of the 1s is held back in a small
//     per-stream store and the other 1 passes through.
//   - Stored 1s are re-emitted, one per cycle, in cycles where both inputs
//     are 0.
//   The number of 1s on each stream is preserved, except for at most DEP 1s
//   that can be held in each store at any time.
//
// Parameters:
//   DEP    maximum number of deferred 1s held per stream (DEP >= 1)
//
// Ports:
//   clk    input   rising-edge clock
//   rst_n  input   asynchronous reset, active low; discards stored 1s
//   in0    input   unipolar bitstream A
//   in1    input   unipolar bitstream B
//   out0   output  decorrelated stream A, registered (1-cycle latency)
//   out1   output  decorrelated stream B, registered (1-cycle latency)
// ---------------------------------------------------------------------------
module skewed_desync_u #(
  parameter int DEP = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in0,
  input  logic in1,
  output logic out0,
  output logic out1
);

  localparam int CW = $clog2(DEP + 1);
  localparam logic [CW-1:0] DEP_C = CW'(DEP);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;
  logic          pri_q,  pri_d;
  logic          out0_q, out0_d;
  logic          out1_q, out1_d;

  logic          sat0;
  logic          sat1;

  assign sat0 = (cnt0_q == DEP_C);
  assign sat1 = (cnt1_q == DEP_C);

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    pri_d  = pri_q;
    out0_d = 1'b0;
    out1_d = 1'b0;

    unique case ({in0, in1})
      2'b11: begin
        // pri selects which stream is preferred for deferral. If that
        // stream's store is full, the other stream is deferred instead.
        // When both stores are full, the coincident 1s pass through together.
        if (!pri_q) begin
          if (!sat1) begin
            cnt1_d = cnt1_q + ONE_C;
            out0_d = 1'b1;
            pri_d  = ~pri_q;
          end else if (!sat0) begin
            cnt0_d = cnt0_q + ONE_C;
            out1_d = 1'b1;
            pri_d  = ~pri_q;
          end else begin
            out0_d = 1'b1;
            out1_d = 1'b1;
          end
        end else begin
          if (!sat0) begin
            cnt0_d = cnt0_q + ONE_C;
            out1_d = 1'b1;
            pri_d  = ~pri_q;
          end else if (!sat1) begin
            cnt1_d = cnt1_q + ONE_C;
            out0_d = 1'b1;
            pri_d  = ~pri_q;
          end else begin
            out0_d = 1'b1;
            out1_d = 1'b1;
          end
        end
      end
      // A single 1 passes through unchanged. No stored 1 is released on the
      // other stream here, because that would create an overlap.
      2'b10: out0_d = 1'b1;
      2'b01: out1_d = 1'b1;
      default: begin
        // Idle cycle: release one stored 1, preferring the fuller store.
        // On a tie, pri decides which stream is released. A release does not
        // change pri.
        if (cnt0_q > cnt1_q) begin
          cnt0_d = cnt0_q - ONE_C;
          out0_d = 1'b1;
        end else if (cnt1_q > cnt0_q) begin
          cnt1_d = cnt1_q - ONE_C;
          out1_d = 1'b1;
        end else if (cnt0_q != '0) begin
          if (!pri_q) begin
            cnt0_d = cnt0_q - ONE_C;
            out0_d = 1'b1;
          end else begin
            cnt1_d = cnt1_q - ONE_C;
            out1_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      pri_q  <= 1'b0;
      out0_q <= 1'b0;
      out1_q <= 1'b0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      pri_q  <= pri_d;
      out0_q <= out0_d;
      out1_q <= out1_d;
    end
  end

  assign out0 = out0_q;
  assign out1 = out1_q;

endmodule

// File: tb/tb_skewed_desync_u.sv
// ---------------------------------------------------------------------------
// tb_skewed_desync_u
//
// Testbench for skewed_desync_u.
// - Two instances share the clock, reset and inputs: one with DEP=2 and one
//   with DEP=4.
// - Directed scenarios check the DEP=2 instance against hand-derived
//   sequences.
// - The random run checks both instances, cycle by cycle, against a
//   behavioural model of the deferral stores. It also checks the
//   conservation and overlap properties on each reset segment.
// ---------------------------------------------------------------------------
module tb_skewed_desync_u;

  logic clk;
  logic rst_n;
  logic in0;
  logic in1;
  logic o2_0, o2_1;
  logic o4_0, o4_1;

  int n_checks;
  int n_fail;

  // Model state, indexed [instance][stream]; instance 0 is DEP=2, 1 is DEP=4.
  int mc[2][2];
  bit mp[2];
  int dep_of[2];

  skewed_desync_u #(.DEP(2)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .in0  (in0),
    .in1  (in1),
    .out0 (o2_0),
    .out1 (o2_1)
  );

  skewed_desync_u #(.DEP(4)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .in0  (in0),
    .in1  (in1),
    .out0 (o4_0),
    .out1 (o4_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input pair and return 1 time unit after the edge that
  // samples it.
  task automatic step(input bit a, input bit b);
    in0 = a;
    in1 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mc[i][0] = 0;
      mc[i][1] = 0;
      mp[i]    = 1'b0;
    end
  endtask

  // Reference model: each stream has a store of pending 1s of capacity dep.
  // A coincident 1 is parked in the preferred store (stream 1 when mp==0),
  // or in the other store if the preferred one is full. Idle cycles pay back
  // one pending 1, taking it from the fuller store first.
  task automatic model_step(input int i, input bit a, input bit b,
                            output bit e0, output bit e1);
    int d;
    int first;
    int hold;
    int rel;
    d  = dep_of[i];
    e0 = 1'b0;
    e1 = 1'b0;
    if (a && b) begin
      first = mp[i] ? 0 : 1;
      if (mc[i][first] < d)          hold = first;
      else if (mc[i][1-first] < d)   hold = 1 - first;
      else                           hold = -1;
      if (hold < 0) begin
        e0 = 1'b1;
        e1 = 1'b1;
      end else begin
        mc[i][hold] = mc[i][hold] + 1;
        if (hold == 0) e1 = 1'b1;
        else           e0 = 1'b1;
        mp[i] = !mp[i];
      end
    end else if (a || b) begin
      e0 = a;
      e1 = b;
    end else if (mc[i][0] + mc[i][1] > 0) begin
      if (mc[i][0] > mc[i][1])      rel = 0;
      else if (mc[i][1] > mc[i][0]) rel = 1;
      else                          rel = mp[i] ? 1 : 0;
      mc[i][rel] = mc[i][rel] - 1;
      if (rel == 0) e0 = 1'b1;
      else          e1 = 1'b1;
    end
  endtask

  task automatic do_reset();
    in0   = 1'b0;
    in1   = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in0   = 1'b1;
    in1   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({o2_0, o2_1, o4_0, o4_1} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_hold got %b expected 0000", {o2_0, o2_1, o4_0, o4_1});
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if ({o2_0, o2_1, o4_0, o4_1} !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL reset_idle[%0d] got %b expected 0000", i, {o2_0, o2_1, o4_0, o4_1});
      end
    end
  endtask

  task automatic test_defer_alternate();
    bit [1:0] exp_in[5];
    bit [1:0] exp_dr[5];
    exp_in = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b11};
    exp_dr = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
    do_reset();
    // Four deferrals fill both DEP=2 stores; the fifth pair saturates.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      n_checks++;
      if ({o2_0, o2_1} !== exp_in[i]) begin
        n_fail++;
        $display("[TB] FAIL defer_alt[%0d] got %b expected %b", i, {o2_0, o2_1}, exp_in[i]);
      end
    end
    // The DEP=4 instance still has room, so the fifth pair is deferred there.
    n_checks++;
    if ({o4_0, o4_1} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL dep4_no_sat got %b expected 10", {o4_0, o4_1});
    end
    // Both stores still hold 2 and pri is 0, so the drain starts on stream 0.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if ({o2_0, o2_1} !== exp_dr[i]) begin
        n_fail++;
        $display("[TB] FAIL sat_drain[%0d] got %b expected %b", i, {o2_0, o2_1}, exp_dr[i]);
      end
    end
  endtask

  task automatic test_drain();
    bit [1:0] exp_dr[5];
    exp_dr = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
    do_reset();
    repeat (4) step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if ({o2_0, o2_1} !== exp_dr[i]) begin
        n_fail++;
        $display("[TB] FAIL drain[%0d] got %b expected %b", i, {o2_0, o2_1}, exp_dr[i]);
      end
    end
  endtask

  task automatic test_no_release_single();
    do_reset();
    step(1'b1, 1'b1);
    n_checks++;
    if ({o2_0, o2_1} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL single_first got %b expected 10", {o2_0, o2_1});
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      n_checks++;
      if ({o2_0, o2_1} !== 2'b10) begin
        n_fail++;
        $display("[TB] FAIL single_hold[%0d] got %b expected 10", i, {o2_0, o2_1});
      end
    end
    step(1'b0, 1'b1);
    n_checks++;
    if ({o2_0, o2_1} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL single_b got %b expected 01", {o2_0, o2_1});
    end
    step(1'b0, 1'b0);
    n_checks++;
    if ({o2_0, o2_1} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL single_release got %b expected 01", {o2_0, o2_1});
    end
    step(1'b0, 1'b0);
    n_checks++;
    if ({o2_0, o2_1} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL single_empty got %b expected 00", {o2_0, o2_1});
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    repeat (3) step(1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o2_0, o2_1, o4_0, o4_1} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL async_clear got %b expected 0000", {o2_0, o2_1, o4_0, o4_1});
    end
    rst_n = 1'b1;
    model_reset();
    // Stored 1s were discarded, so idle cycles emit nothing.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if ({o2_0, o2_1, o4_0, o4_1} !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL discard[%0d] got %b expected 0000", i, {o2_0, o2_1, o4_0, o4_1});
      end
    end
  endtask

  task automatic test_random();
    int ones_in[2];
    int ones_out[2][2];
    int ovl_in;
    int ovl_out[2];
    bit a, b, e0, e1, g0, g1;
    do_reset();
    ones_in  = '{0, 0};
    ones_out = '{'{0, 0}, '{0, 0}};
    ovl_in   = 0;
    ovl_out  = '{0, 0};
    for (int cyc = 1; cyc <= 10000; cyc++) begin
      a = ($urandom % 4) < 2;
      b = ($urandom % 4) < 3;
      step(a, b);
      ones_in[0] += int'(a);
      ones_in[1] += int'(b);
      ovl_in     += int'(a & b);
      for (int i = 0; i < 2; i++) begin
        model_step(i, a, b, e0, e1);
        g0 = (i == 0) ? o2_0 : o4_0;
        g1 = (i == 0) ? o2_1 : o4_1;
        ones_out[i][0] += int'(g0);
        ones_out[i][1] += int'(g1);
        ovl_out[i]     += int'(g0 & g1);
        n_checks++;
        if ({g0, g1} !== {e0, e1}) begin
          n_fail++;
          $display("[TB] FAIL rand_dep%0d cycle %0d got %b expected %b", dep_of[i], cyc, {g0, g1}, {e0, e1});
        end
      end
      if (cyc == 5000 || cyc == 10000) begin
        for (int i = 0; i < 2; i++) begin
          for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (ones_in[k] - ones_out[i][k] != mc[i][k] ||
                mc[i][k] < 0 || mc[i][k] > dep_of[i]) begin
              n_fail++;
              $display("[TB] FAIL conserve_dep%0d_s%0d cycle %0d got %0d pending expected %0d",
                       dep_of[i], k, cyc, ones_in[k] - ones_out[i][k], mc[i][k]);
            end
          end
          n_checks++;
          if (ovl_out[i] > ovl_in) begin
            n_fail++;
            $display("[TB] FAIL overlap_dep%0d cycle %0d got %0d expected <= %0d",
                     dep_of[i], cyc, ovl_out[i], ovl_in);
          end
        end
      end
      if (cyc == 5000) begin
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o2_0, o2_1, o4_0, o4_1} !== 4'b0000) begin
          n_fail++;
          $display("[TB] FAIL rand_reset got %b expected 0000", {o2_0, o2_1, o4_0, o4_1});
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        ones_in  = '{0, 0};
        ones_out = '{'{0, 0}, '{0, 0}};
        ovl_in   = 0;
        ovl_out  = '{0, 0};
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    dep_of[0] = 2;
    dep_of[1] = 4;
    rst_n     = 1'b0;
    in0       = 1'b0;
    in1       = 1'b0;
    model_reset();
    test_reset();
    test_defer_alternate();
    test_drain();
    test_no_release_single();
    test_midstream_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
